lsu_stbuf_queue: RTL and testbench
==================================

# lsu_stbuf_queue

Store buffer that sits directly upstream of the DCCM/PIC control stage. It accepts committed stores, holds them in an in-order queue and presents the oldest entry as a single write request. It retires that entry when the control stage grants the port via `lsu_stbuf_commit_any`. It also returns registered per-byte forwarding data so that younger loads see pending store bytes.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, `RV_DCCM_BITS`: byte-address width.
- `DATA_W`, 32: entry data width; byte lanes = DATA_W/8.
---
- `clk`  in  1  core clock.
- `rst_l`  in  1  reset; synchronous, active-low.
- `st_valid`  in  1  committed store enqueue request.
- `st_addr`  in  ADDR_W  store byte address; bits [1:0] are ignored, because the entry is word-aligned.
- `st_byteen`  in  4  byte enables, already lane-aligned.
- `st_data`  in  DATA_W  store data, already lane-aligned.
- `st_in_pic`  in  1  store targets PIC.
- `stbuf_full`  out  1  count == DEPTH.
- `stbuf_empty`  out  1  count == 0.
- `stbuf_reqvld_any`  out  1  head entry valid.
- `stbuf_addr_any`  out  ADDR_W  head word address, with [1:0] = 0.
- `stbuf_data_any`  out  DATA_W  head data.
- `stbuf_byteen_any`  out  4  head byte enables.
- `stbuf_addr_in_pic_any`  out  1  head PIC flag.
- `lsu_stbuf_commit_any`  in  1  head accepted this cycle.
- `fwd_valid_dc2`, `fwd_addr_lo_dc2`, `fwd_addr_hi_dc2`  in  1/ADDR_W/ADDR_W  load lookup.
- `stbuf_fwddata_lo_dc3`, `stbuf_fwddata_hi_dc3`  out  DATA_W  forwarded bytes.
- `stbuf_fwdbyteen_lo_dc3`, `stbuf_fwdbyteen_hi_dc3`  out  4  forwarded-byte valid.

## Operation
- **Storage:** circular queue with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits. Each entry holds {valid, addr, byteen, data, pic}.
- **Enqueue accept:** an enqueue is accepted when `st_valid` and either count < DEPTH or `lsu_stbuf_commit_any` in the same cycle (full with simultaneous drain is legal). Enqueue while full without a drain is dropped. Upstream must not issue it; the bench checks it as an assertion.
- **Coalescing:** when the incoming word address and PIC flag equal the youngest valid entry, and that entry is not the head being committed this cycle, the store merges into that entry byte-wise; the new bytes win and `byteen` is ORed. Tail and count are unchanged. Coalescing never applies when count == 0.
- **Drain:** `lsu_stbuf_commit_any` with `stbuf_reqvld_any` frees the head. The head pointer advances and the entry is invalidated. A commit while the queue is empty is ignored.
- **Count update:** +1 for a non-merging enqueue, −1 for a drain, unchanged when both or neither occur.
- **Forwarding:**
  - On `fwd_valid_dc2`, for each of lo/hi and each byte lane, select the youngest matching entry: valid, word address equal, byteen bit set. PIC entries never forward.
  - The entry being drained this cycle still participates.
  - A store being enqueued or merged in the same cycle participates as youngest (bypass).
  - The result is registered into the `_dc3` outputs. When there is no lookup, the byte enables register to 0.
- **Reset:** all entries are invalid and both pointers and the count are 0. `stbuf_empty` = 1; `stbuf_full`, `stbuf_reqvld_any` and all forward byte enables are 0; data and address outputs are 0. A reset mid-operation discards all pending stores.

## Timing
- **Enqueue to request:** an enqueue at edge N gives `stbuf_reqvld_any` = 1 in cycle N+1 when the queue was empty.
- **Head outputs:** the head outputs come directly from flops, with no combinational path from `st_*`.
- **Commit path:** `lsu_stbuf_commit_any` affects state only at the next edge. It has no combinational path to the head outputs.
- **Forward latency:** one cycle, dc2 lookup to dc3 outputs.
- **Flags:** `stbuf_full` and `stbuf_empty` reflect the registered count.

## Structure
- **Shared package (`swerv_types`):** the `stbuf_entry_t` struct {valid, pic, addr, byteen, data}.
- **Shared constants:** `RV_LSU_STBUF_DEPTH`, which defaults `DEPTH`.
- **Sub-module `lsu_stbuf_fwd`:** one natural sub-module. It takes the entry array, head pointer and lookup address, and produces a youngest-first per-byte priority select. It is instantiated twice, for lo and hi.

## Test plan
- **Basic enqueue/drain:** after reset, enqueue addr 0x100, byteen 4'hF, data 0xDEADBEEF → next cycle reqvld = 1 with addr 0x100 and that data. Commit → empty = 1 the following cycle.
- **Fill and wrap:** enqueue 4 stores → full = 1. Fifth enqueue with a simultaneous commit → accepted, count stays 4, head advances. Then run 8 more enqueue/drain pairs to exercise pointer wrap; drain order equals enqueue order.
- **Coalescing:** enqueue 0x200/4'h3/0x0000_1122, then 0x202/4'hC/0x3344_0000 while the head is not committing → one entry, byteen 4'hF, data 0x3344_1122.
- **Youngest-wins forwarding:** entries at 0x300 with data 0xAAAAAAAA (4'hF) then 0x300 with 0x000000BB (4'h1). Lookup lo = 0x300 → next cycle fwdbyteen_lo = 4'hF, fwddata_lo = 0xAAAAAABB. Same lookup with a PIC entry only → byteen 0.
- **Bypass:** lookup in the same cycle as enqueue 0x400/4'h1/0xCC → dc3 byteen_lo = 4'h1, data byte0 = 0xCC.
- **Reset mid-operation:** rst_l low for 1 cycle with 3 entries queued → empty = 1, reqvld = 0, fwd byteen = 0 next cycle. A commit during reset has no effect.

Source files
------------

// File: rtl/lsu_stbuf_queue_pkg.sv
// Shared types and constants for the LSU store buffer.
// Also holds the word-alignment and byte-merge helpers used by the queue and the forwarding logic.
package lsu_stbuf_queue_pkg;

    localparam int RV_DCCM_BITS       = 16;
    localparam int RV_LSU_STBUF_DEPTH = 4;
    localparam int STBUF_DATA_W       = 32;
    localparam int STBUF_BYTES        = STBUF_DATA_W / 8;

    typedef struct packed {
        logic                    valid;
        logic                    pic;
        logic [RV_DCCM_BITS-1:0] addr;
        logic [STBUF_BYTES-1:0]  byteen;
        logic [STBUF_DATA_W-1:0] data;
    } stbuf_entry_t;

    function automatic logic [RV_DCCM_BITS-1:0] word_addr(input logic [RV_DCCM_BITS-1:0] a);
        return {a[RV_DCCM_BITS-1:2], 2'b00};
    endfunction

    function automatic logic [STBUF_DATA_W-1:0] merge_bytes(
        input logic [STBUF_DATA_W-1:0] old_d,
        input logic [STBUF_DATA_W-1:0] new_d,
        input logic [STBUF_BYTES-1:0]  be
    );
        logic [STBUF_DATA_W-1:0] res;
        res = old_d;
        for (int j = 0; j < STBUF_BYTES; j++) begin
            if (be[j]) res[8*j +: 8] = new_d[8*j +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_stbuf_queue_if.sv
// Store-buffer bus: store enqueue, head write request/commit and load forwarding lookup.
interface lsu_stbuf_queue_if
    import lsu_stbuf_queue_pkg::*;
#(
    parameter int ADDR_W = RV_DCCM_BITS,
    parameter int DATA_W = STBUF_DATA_W
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [3:0]        st_byteen;
    logic [DATA_W-1:0] st_data;
    logic              st_in_pic;

    logic              stbuf_full;
    logic              stbuf_empty;
    logic              stbuf_reqvld_any;
    logic [ADDR_W-1:0] stbuf_addr_any;
    logic [DATA_W-1:0] stbuf_data_any;
    logic [3:0]        stbuf_byteen_any;
    logic              stbuf_addr_in_pic_any;
    logic              lsu_stbuf_commit_any;

    logic              fwd_valid_dc2;
    logic [ADDR_W-1:0] fwd_addr_lo_dc2;
    logic [ADDR_W-1:0] fwd_addr_hi_dc2;
    logic [DATA_W-1:0] stbuf_fwddata_lo_dc3;
    logic [DATA_W-1:0] stbuf_fwddata_hi_dc3;
    logic [3:0]        stbuf_fwdbyteen_lo_dc3;
    logic [3:0]        stbuf_fwdbyteen_hi_dc3;

    modport master (
        output st_valid, st_addr, st_byteen, st_data, st_in_pic,
        output lsu_stbuf_commit_any,
        output fwd_valid_dc2, fwd_addr_lo_dc2, fwd_addr_hi_dc2,
        input  stbuf_full, stbuf_empty, stbuf_reqvld_any, stbuf_addr_any,
        input  stbuf_data_any, stbuf_byteen_any, stbuf_addr_in_pic_any,
        input  stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3,
        input  stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3
    );

    modport slave (
        input  st_valid, st_addr, st_byteen, st_data, st_in_pic,
        input  lsu_stbuf_commit_any,
        input  fwd_valid_dc2, fwd_addr_lo_dc2, fwd_addr_hi_dc2,
        output stbuf_full, stbuf_empty, stbuf_reqvld_any, stbuf_addr_any,
        output stbuf_data_any, stbuf_byteen_any, stbuf_addr_in_pic_any,
        output stbuf_fwddata_lo_dc3, stbuf_fwddata_hi_dc3,
        output stbuf_fwdbyteen_lo_dc3, stbuf_fwdbyteen_hi_dc3
    );

endinterface

// File: rtl/lsu_stbuf_queue_fwd.sv
// Per-byte store-to-load forwarding select for one lookup address.
// Entries are walked oldest to youngest, so younger matches overwrite older ones.
module lsu_stbuf_fwd
    import lsu_stbuf_queue_pkg::*;
#(
    parameter int DEPTH = RV_LSU_STBUF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  stbuf_entry_t            ent [DEPTH],
    input  logic [PTR_W-1:0]        head,
    input  logic [RV_DCCM_BITS-1:0] lk_addr,
    input  stbuf_entry_t            byp,
    output logic [STBUF_BYTES-1:0]  fwd_byteen,
    output logic [STBUF_DATA_W-1:0] fwd_data
);

    logic [RV_DCCM_BITS-1:0] lk_word;
    logic [PTR_W-1:0]        idx;

    assign lk_word = word_addr(lk_addr);

    always_comb begin
        fwd_byteen = '0;
        fwd_data   = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (ent[idx].valid && !ent[idx].pic && (ent[idx].addr == lk_word)) begin
                for (int j = 0; j < STBUF_BYTES; j++) begin
                    if (ent[idx].byteen[j]) begin
                        fwd_byteen[j]     = 1'b1;
                        fwd_data[8*j +: 8] = ent[idx].data[8*j +: 8];
                    end
                end
            end
        end
        // The store arriving this cycle is younger than anything already queued.
        if (byp.valid && !byp.pic && (byp.addr == lk_word)) begin
            for (int j = 0; j < STBUF_BYTES; j++) begin
                if (byp.byteen[j]) begin
                    fwd_byteen[j]     = 1'b1;
                    fwd_data[8*j +: 8] = byp.data[8*j +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/lsu_stbuf_queue.sv
// In-order store buffer feeding the DCCM/PIC control stage, with coalescing
// into the youngest entry and registered per-byte forwarding for loads.
module lsu_stbuf_queue
    import lsu_stbuf_queue_pkg::*;
#(
    parameter int DEPTH = RV_LSU_STBUF_DEPTH
) (
    input logic               clk,
    input logic               rst_l,
    lsu_stbuf_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    stbuf_entry_t            ent [DEPTH];
    stbuf_entry_t            head_ent;
    stbuf_entry_t            st_ent;
    stbuf_entry_t            byp;
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [PTR_W-1:0]        yidx;
    logic [CNT_W-1:0]        count;
    logic                    drain;
    logic                    has_room;
    logic                    do_merge;
    logic                    do_push;

    logic [STBUF_BYTES-1:0]  fwd_be_lo, fwd_be_hi;
    logic [STBUF_DATA_W-1:0] fwd_d_lo, fwd_d_hi;
    logic [STBUF_BYTES-1:0]  fwd_be_lo_q, fwd_be_hi_q;
    logic [STBUF_DATA_W-1:0] fwd_d_lo_q, fwd_d_hi_q;

    assign head_ent = ent[head];
    assign yidx     = tail - PTR_W'(1);
    assign drain    = bus.lsu_stbuf_commit_any && head_ent.valid;
    assign has_room = (count != CNT_W'(DEPTH));

    always_comb begin
        st_ent        = '0;
        st_ent.valid  = bus.st_valid;
        st_ent.pic    = bus.st_in_pic;
        st_ent.addr   = word_addr(bus.st_addr);
        st_ent.byteen = bus.st_byteen;
        st_ent.data   = bus.st_data;
    end

    // A head that leaves this cycle can no longer absorb a merge.
    assign do_merge = bus.st_valid && (count != '0) && ent[yidx].valid
                      && (ent[yidx].addr == st_ent.addr) && (ent[yidx].pic == st_ent.pic)
                      && !(drain && (yidx == head));
    assign do_push  = bus.st_valid && !do_merge && (has_room || drain);

    always_comb begin
        byp       = st_ent;
        byp.valid = do_merge || do_push;
    end

    lsu_stbuf_fwd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_lo (
        .ent        (ent),
        .head       (head),
        .lk_addr    (bus.fwd_addr_lo_dc2),
        .byp        (byp),
        .fwd_byteen (fwd_be_lo),
        .fwd_data   (fwd_d_lo)
    );

    lsu_stbuf_fwd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_hi (
        .ent        (ent),
        .head       (head),
        .lk_addr    (bus.fwd_addr_hi_dc2),
        .byp        (byp),
        .fwd_byteen (fwd_be_hi),
        .fwd_data   (fwd_d_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            fwd_be_lo_q <= '0;
            fwd_be_hi_q <= '0;
            fwd_d_lo_q  <= '0;
            fwd_d_hi_q  <= '0;
        end else begin
            if (drain) begin
                ent[head].valid <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            // When full with a drain, tail == head and the new entry overrides the invalidate.
            if (do_push) begin
                ent[tail] <= st_ent;
                tail      <= tail + PTR_W'(1);
            end
            if (do_merge) begin
                ent[yidx].byteen <= ent[yidx].byteen | st_ent.byteen;
                ent[yidx].data   <= merge_bytes(ent[yidx].data, st_ent.data, st_ent.byteen);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(drain);

            fwd_be_lo_q <= bus.fwd_valid_dc2 ? fwd_be_lo : '0;
            fwd_be_hi_q <= bus.fwd_valid_dc2 ? fwd_be_hi : '0;
            fwd_d_lo_q  <= bus.fwd_valid_dc2 ? fwd_d_lo  : '0;
            fwd_d_hi_q  <= bus.fwd_valid_dc2 ? fwd_d_hi  : '0;
        end
    end

    assign bus.stbuf_full            = (count == CNT_W'(DEPTH));
    assign bus.stbuf_empty           = (count == '0);
    assign bus.stbuf_reqvld_any      = head_ent.valid;
    assign bus.stbuf_addr_any        = head_ent.addr;
    assign bus.stbuf_data_any        = head_ent.data;
    assign bus.stbuf_byteen_any      = head_ent.byteen;
    assign bus.stbuf_addr_in_pic_any = head_ent.pic;

    assign bus.stbuf_fwddata_lo_dc3   = fwd_d_lo_q;
    assign bus.stbuf_fwddata_hi_dc3   = fwd_d_hi_q;
    assign bus.stbuf_fwdbyteen_lo_dc3 = fwd_be_lo_q;
    assign bus.stbuf_fwdbyteen_hi_dc3 = fwd_be_hi_q;

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Directed bench for lsu_stbuf_queue: stimulus pushes expected drains and
// forwarding results; a negedge monitor pops and compares them.
module tb_lsu_stbuf_queue;
    import lsu_stbuf_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    lsu_stbuf_queue_if bus ();

    lsu_stbuf_queue dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        pic;
    } drain_t;

    typedef struct {
        logic [3:0]  be_lo;
        logic [31:0] d_lo;
        logic [3:0]  be_hi;
        logic [31:0] d_hi;
    } fwd_t;

    drain_t drain_q[$];
    fwd_t   fwd_q[$];
    int     total = 0;
    int     bad   = 0;
    bit     lk_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hFF;
        return m;
    endfunction

    // Monitor: checks dc3 forwarding one cycle after each lookup and head contents on each drain.
    initial begin
        forever begin
            @(negedge clk);
            if (lk_pending) begin
                if (fwd_q.size() == 0) begin
                    chk("fwd_unexpected", 32'h1, 32'h0);
                end else begin
                    fwd_t f;
                    f = fwd_q.pop_front();
                    chk("fwd_be_lo", {28'h0, bus.stbuf_fwdbyteen_lo_dc3}, {28'h0, f.be_lo});
                    chk("fwd_data_lo", bus.stbuf_fwddata_lo_dc3 & be_mask(f.be_lo), f.d_lo & be_mask(f.be_lo));
                    chk("fwd_be_hi", {28'h0, bus.stbuf_fwdbyteen_hi_dc3}, {28'h0, f.be_hi});
                    chk("fwd_data_hi", bus.stbuf_fwddata_hi_dc3 & be_mask(f.be_hi), f.d_hi & be_mask(f.be_hi));
                end
            end
            lk_pending = rst_l && bus.fwd_valid_dc2;
            if (rst_l && bus.lsu_stbuf_commit_any && bus.stbuf_reqvld_any) begin
                if (drain_q.size() == 0) begin
                    chk("drain_unexpected", 32'h1, 32'h0);
                end else begin
                    drain_t d;
                    d = drain_q.pop_front();
                    chk("drain_addr", {16'h0, bus.stbuf_addr_any}, {16'h0, d.addr});
                    chk("drain_data", bus.stbuf_data_any, d.data);
                    chk("drain_be", {28'h0, bus.stbuf_byteen_any}, {28'h0, d.be});
                    chk("drain_pic", {31'h0, bus.stbuf_addr_in_pic_any}, {31'h0, d.pic});
                end
            end
            if (rst_l && bus.st_valid && bus.stbuf_full && !bus.lsu_stbuf_commit_any)
                chk("enq_while_full", 32'h1, 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.st_valid             = 1'b0;
        bus.lsu_stbuf_commit_any = 1'b0;
        bus.fwd_valid_dc2        = 1'b0;
    endtask

    task automatic set_st(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d, input logic pic);
        bus.st_valid  = 1'b1;
        bus.st_addr   = a;
        bus.st_byteen = be;
        bus.st_data   = d;
        bus.st_in_pic = pic;
    endtask

    task automatic exp_drain(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be, input logic pic);
        drain_t x;
        x.addr = a; x.data = d; x.be = be; x.pic = pic;
        drain_q.push_back(x);
    endtask

    task automatic lookup(input logic [15:0] lo, input logic [15:0] hi,
                          input logic [3:0] be_lo, input logic [31:0] d_lo,
                          input logic [3:0] be_hi, input logic [31:0] d_hi);
        fwd_t f;
        bus.fwd_valid_dc2   = 1'b1;
        bus.fwd_addr_lo_dc2 = lo;
        bus.fwd_addr_hi_dc2 = hi;
        f.be_lo = be_lo; f.d_lo = d_lo; f.be_hi = be_hi; f.d_hi = d_hi;
        fwd_q.push_back(f);
    endtask

    initial begin
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_byteen = '0; bus.st_data = '0; bus.st_in_pic = 1'b0;
        bus.lsu_stbuf_commit_any = 1'b0;
        bus.fwd_valid_dc2 = 1'b0; bus.fwd_addr_lo_dc2 = '0; bus.fwd_addr_hi_dc2 = '0;
        rst_l = 1'b0;
        cyc(); cyc();
        rst_l = 1'b1;
        chk("rst_empty", {31'h0, bus.stbuf_empty}, 32'h1);
        chk("rst_full", {31'h0, bus.stbuf_full}, 32'h0);
        chk("rst_reqvld", {31'h0, bus.stbuf_reqvld_any}, 32'h0);
        chk("rst_fwdbe_lo", {28'h0, bus.stbuf_fwdbyteen_lo_dc3}, 32'h0);
        chk("rst_fwdbe_hi", {28'h0, bus.stbuf_fwdbyteen_hi_dc3}, 32'h0);
        chk("rst_addr", {16'h0, bus.stbuf_addr_any}, 32'h0);
        chk("rst_data", bus.stbuf_data_any, 32'h0);

        // Basic enqueue then drain.
        set_st(16'h0100, 4'hF, 32'hDEADBEEF, 1'b0);
        exp_drain(16'h0100, 32'hDEADBEEF, 4'hF, 1'b0);
        cyc();
        chk("basic_reqvld", {31'h0, bus.stbuf_reqvld_any}, 32'h1);
        chk("basic_addr", {16'h0, bus.stbuf_addr_any}, 32'h0000_0100);
        chk("basic_data", bus.stbuf_data_any, 32'hDEADBEEF);
        chk("basic_not_empty", {31'h0, bus.stbuf_empty}, 32'h0);
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("basic_empty", {31'h0, bus.stbuf_empty}, 32'h1);

        // Fill to full, then full-with-drain enqueue, then wrap.
        for (int k = 0; k < 4; k++) begin
            set_st(16'h0010 + 16'(4*k), 4'hF, 32'hA000_0000 + 32'(k), 1'b0);
            exp_drain(16'h0010 + 16'(4*k), 32'hA000_0000 + 32'(k), 4'hF, 1'b0);
            cyc();
        end
        chk("fill_full", {31'h0, bus.stbuf_full}, 32'h1);
        set_st(16'h0020, 4'hF, 32'hA000_0004, 1'b0);
        exp_drain(16'h0020, 32'hA000_0004, 4'hF, 1'b0);
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("fill_full_after_swap", {31'h0, bus.stbuf_full}, 32'h1);
        chk("fill_head_advanced", {16'h0, bus.stbuf_addr_any}, 32'h0000_0014);
        for (int k = 0; k < 8; k++) begin
            set_st(16'h0024 + 16'(4*k), 4'hF, 32'hB000_0000 + 32'(k), 1'b0);
            exp_drain(16'h0024 + 16'(4*k), 32'hB000_0000 + 32'(k), 4'hF, 1'b0);
            bus.lsu_stbuf_commit_any = 1'b1;
            cyc();
        end
        chk("wrap_full", {31'h0, bus.stbuf_full}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            bus.lsu_stbuf_commit_any = 1'b1;
            cyc();
        end
        chk("wrap_empty", {31'h0, bus.stbuf_empty}, 32'h1);

        // Commit with nothing queued must not disturb the count.
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("idle_commit_empty", {31'h0, bus.stbuf_empty}, 32'h1);
        chk("idle_commit_full", {31'h0, bus.stbuf_full}, 32'h0);

        // Coalescing into the youngest entry.
        set_st(16'h0200, 4'h3, 32'h0000_1122, 1'b0);
        cyc();
        set_st(16'h0202, 4'hC, 32'h3344_0000, 1'b0);
        cyc();
        chk("coal_addr", {16'h0, bus.stbuf_addr_any}, 32'h0000_0200);
        chk("coal_be", {28'h0, bus.stbuf_byteen_any}, 32'hF);
        chk("coal_data", bus.stbuf_data_any, 32'h3344_1122);
        exp_drain(16'h0200, 32'h3344_1122, 4'hF, 1'b0);
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("coal_single_entry", {31'h0, bus.stbuf_empty}, 32'h1);

        // Youngest entry wins per byte; a draining head still forwards.
        set_st(16'h0300, 4'hF, 32'hAAAA_AAAA, 1'b0);
        exp_drain(16'h0300, 32'hAAAA_AAAA, 4'hF, 1'b0);
        cyc();
        set_st(16'h0304, 4'hF, 32'h1111_1111, 1'b0);
        exp_drain(16'h0304, 32'h1111_1111, 4'hF, 1'b0);
        cyc();
        set_st(16'h0300, 4'h1, 32'h0000_00BB, 1'b0);
        exp_drain(16'h0300, 32'h0000_00BB, 4'h1, 1'b0);
        cyc();
        lookup(16'h0302, 16'h0304, 4'hF, 32'hAAAA_AABB, 4'hF, 32'h1111_1111);
        cyc();
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        bus.lsu_stbuf_commit_any = 1'b1;
        lookup(16'h0300, 16'h0304, 4'h1, 32'h0000_00BB, 4'hF, 32'h1111_1111);
        cyc();
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("ywin_empty", {31'h0, bus.stbuf_empty}, 32'h1);

        // PIC entries never forward.
        set_st(16'h0500, 4'hF, 32'h5555_5555, 1'b1);
        exp_drain(16'h0500, 32'h5555_5555, 4'hF, 1'b1);
        cyc();
        chk("pic_flag", {31'h0, bus.stbuf_addr_in_pic_any}, 32'h1);
        lookup(16'h0500, 16'h0300, 4'h0, 32'h0, 4'h0, 32'h0);
        cyc();
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();

        // Bypass of a same-cycle enqueue and a same-cycle merge.
        set_st(16'h0400, 4'h1, 32'h0000_00CC, 1'b0);
        lookup(16'h0400, 16'h0404, 4'h1, 32'h0000_00CC, 4'h0, 32'h0);
        cyc();
        set_st(16'h0400, 4'h2, 32'h0000_DD00, 1'b0);
        lookup(16'h0401, 16'h0400, 4'h3, 32'h0000_DDCC, 4'h3, 32'h0000_DDCC);
        cyc();
        exp_drain(16'h0400, 32'h0000_DDCC, 4'h3, 1'b0);
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("byp_empty", {31'h0, bus.stbuf_empty}, 32'h1);

        // Reset with entries pending, commit and lookup held during reset.
        set_st(16'h0600, 4'hF, 32'h6666_0000, 1'b0);
        cyc();
        set_st(16'h0604, 4'hF, 32'h6666_0004, 1'b0);
        cyc();
        set_st(16'h0608, 4'hF, 32'h6666_0008, 1'b0);
        cyc();
        chk("prerst_reqvld", {31'h0, bus.stbuf_reqvld_any}, 32'h1);
        rst_l = 1'b0;
        bus.lsu_stbuf_commit_any = 1'b1;
        bus.fwd_valid_dc2   = 1'b1;
        bus.fwd_addr_lo_dc2 = 16'h0600;
        bus.fwd_addr_hi_dc2 = 16'h0604;
        cyc();
        rst_l = 1'b1;
        chk("midrst_empty", {31'h0, bus.stbuf_empty}, 32'h1);
        chk("midrst_full", {31'h0, bus.stbuf_full}, 32'h0);
        chk("midrst_reqvld", {31'h0, bus.stbuf_reqvld_any}, 32'h0);
        chk("midrst_fwdbe_lo", {28'h0, bus.stbuf_fwdbyteen_lo_dc3}, 32'h0);
        chk("midrst_fwdbe_hi", {28'h0, bus.stbuf_fwdbyteen_hi_dc3}, 32'h0);
        set_st(16'h0700, 4'hF, 32'h7777_7777, 1'b0);
        exp_drain(16'h0700, 32'h7777_7777, 4'hF, 1'b0);
        cyc();
        chk("postrst_reqvld", {31'h0, bus.stbuf_reqvld_any}, 32'h1);
        chk("postrst_addr", {16'h0, bus.stbuf_addr_any}, 32'h0000_0700);
        bus.lsu_stbuf_commit_any = 1'b1;
        cyc();
        chk("postrst_empty", {31'h0, bus.stbuf_empty}, 32'h1);

        cyc(); cyc();
        chk("drain_q_left", drain_q.size(), 32'h0);
        chk("fwd_q_left", fwd_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
